// File: rtl/hist_pkg.sv
// Shared types and default widths for the state histogram logger.
package hist_pkg;

  localparam int DefaultOutW    = 16;
  localparam int DefaultNumBins = 90;
  localparam int DefaultCntW    = 32;
  localparam int DefaultLimW    = 40;

  typedef enum logic [1:0] {
    StIdle,
    StAcquire,
    StDrain,
    StDone
  } hist_state_e;

endpackage

// File: rtl/hist_match_encoder.sv
// Combinational priority matcher: lowest-index table entry equal to value wins.
module hist_match_encoder #(
  parameter int OUT_W    = 16,
  parameter int NUM_BINS = 90,
  parameter int BIN_W    = 7
) (
  input  logic [NUM_BINS*OUT_W-1:0] tbl_i,
  input  logic [OUT_W-1:0]          value_i,
  output logic                      hit_o,
  output logic [BIN_W-1:0]          bin_o
);

  // Scan from the top down so the lowest matching index is the last one written.
  always_comb begin
    hit_o = 1'b0;
    bin_o = '0;
    for (int i = NUM_BINS - 1; i >= 0; i--) begin
      if (tbl_i[i*OUT_W +: OUT_W] == value_i) begin
        hit_o = 1'b1;
        bin_o = BIN_W'(i);
      end
    end
  end

endmodule

// File: rtl/state_histogram_logger.sv
// State histogram logger: counts occurrences of tracked state values over a run, then
// streams every bin out over a valid/ready port.
// Optional feature: define HIST_OTHER_BIN_EN to add a catch-all bin for unmatched samples.
module state_histogram_logger
  import hist_pkg::*;
#(
  parameter int  OUT_W    = DefaultOutW,
  parameter int  NUM_BINS = DefaultNumBins,
  parameter int  CNT_W    = DefaultCntW,
  parameter int  LIM_W    = DefaultLimW,
  localparam int BIN_W    = $clog2(NUM_BINS + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             clear,
  input  logic [LIM_W-1:0] sample_limit,
  input  logic [OUT_W-1:0] out,
  input  logic             update_cycle_done,
  input  logic             tbl_we,
  input  logic [BIN_W-1:0] tbl_addr,
  input  logic [OUT_W-1:0] tbl_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [BIN_W-1:0] rd_bin,
  output logic [CNT_W-1:0] rd_count,
  output logic             rd_last,
  output logic             busy,
  output logic             done
);

`ifdef HIST_OTHER_BIN_EN
  localparam int NumCnt  = NUM_BINS + 1;
  localparam bit OtherEn = 1'b1;
`else
  localparam int NumCnt  = NUM_BINS;
  localparam bit OtherEn = 1'b0;
`endif
  localparam logic [BIN_W-1:0] LastIdx = BIN_W'(NumCnt - 1);

  hist_state_e state_q, state_d;

  logic [OUT_W-1:0]          tbl_q [NUM_BINS];
  logic [NUM_BINS*OUT_W-1:0] tbl_flat;
  logic [CNT_W-1:0]          bins_q [NumCnt];
  logic [LIM_W-1:0]          scnt_q, lim_q;
  logic                      samp_vld_q;
  logic [OUT_W-1:0]          samp_q;
  logic [BIN_W-1:0]          rd_idx_q;

  logic             idle_or_done, start_go, zero, lim_hit, accept;
  logic             hit, upd_en;
  logic [BIN_W-1:0] hit_bin, upd_bin;

  assign idle_or_done = (state_q == StIdle) || (state_q == StDone);
  assign start_go     = start && !clear && idle_or_done;
  assign zero         = clear || start_go;
  assign lim_hit      = (lim_q != '0) && (scnt_q == lim_q);
  assign accept       = (state_q == StAcquire) && update_cycle_done && !lim_hit && !clear;

  // Unmatched samples fall into the catch-all bin only when it exists.
  assign upd_en  = samp_vld_q && (hit || OtherEn);
  assign upd_bin = hit ? hit_bin : BIN_W'(NUM_BINS);

  // Flatten the table for the matcher.
  always_comb begin
    tbl_flat = '0;
    for (int i = 0; i < NUM_BINS; i++) begin
      tbl_flat[i*OUT_W +: OUT_W] = tbl_q[i];
    end
  end

  hist_match_encoder #(
    .OUT_W    (OUT_W),
    .NUM_BINS (NUM_BINS),
    .BIN_W    (BIN_W)
  ) u_match (
    .tbl_i   (tbl_flat),
    .value_i (samp_q),
    .hit_o   (hit),
    .bin_o   (hit_bin)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // Next-state logic; clear overrides everything.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: if (start) state_d = StAcquire;
      StAcquire:      if (lim_hit && !samp_vld_q) state_d = StDrain;
      StDrain:        if (rd_ready && rd_last) state_d = StDone;
      default:        state_d = StIdle;
    endcase
    if (clear) state_d = StIdle;
  end

  // Tracked-state table, writable only while not acquiring or draining.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_BINS; i++) tbl_q[i] <= OUT_W'(i);
    end else if (tbl_we && idle_or_done && (tbl_addr < BIN_W'(NUM_BINS))) begin
      for (int i = 0; i < NUM_BINS; i++) begin
        if (tbl_addr == BIN_W'(i)) tbl_q[i] <= tbl_data;
      end
    end
  end

  // One-stage sample pipeline in front of the matcher.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      samp_vld_q <= 1'b0;
      samp_q     <= '0;
    end else begin
      samp_vld_q <= accept;
      if (accept) samp_q <= out;
    end
  end

  // Sample counter and the limit captured at start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scnt_q <= '0;
      lim_q  <= '0;
    end else begin
      if (zero)        scnt_q <= '0;
      else if (accept) scnt_q <= scnt_q + 1'b1;
      if (start_go)    lim_q  <= sample_limit;
    end
  end

  // Saturating bin counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NumCnt; i++) bins_q[i] <= '0;
    end else begin
      for (int i = 0; i < NumCnt; i++) begin
        if (zero) begin
          bins_q[i] <= '0;
        end else if (upd_en && (upd_bin == BIN_W'(i)) && (bins_q[i] != '1)) begin
          bins_q[i] <= bins_q[i] + 1'b1;
        end
      end
    end
  end

  // Readout index; holds on the final word so outputs stay put in DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_idx_q <= '0;
    end else if (zero) begin
      rd_idx_q <= '0;
    end else if ((state_q == StDrain) && rd_ready && (rd_idx_q != LastIdx)) begin
      rd_idx_q <= rd_idx_q + 1'b1;
    end
  end

  // Readout word mux and status outputs.
  always_comb begin
    rd_count = '0;
    for (int i = 0; i < NumCnt; i++) begin
      if (rd_idx_q == BIN_W'(i)) rd_count = bins_q[i];
    end
    rd_bin   = rd_idx_q;
    rd_valid = (state_q == StDrain);
    rd_last  = (state_q == StDrain) && (rd_idx_q == LastIdx);
    busy     = (state_q == StAcquire) || (state_q == StDrain);
    done     = (state_q == StDone);
  end

endmodule

// File: doc/state_histogram_logger.md
STATE_HISTOGRAM_LOGGER -- requirements
Module: state_histogram_logger

Interface
REQ-001 SHALL have parameter OUT_W, default 16, sampled state width in bits.
REQ-002 SHALL have parameter NUM_BINS, default 90, number of tracked-state bins (>=2).
REQ-003 SHALL have parameter CNT_W, default 32, per-bin counter width.
REQ-004 SHALL have parameter LIM_W, default 40, sample-limit and sample-counter width.
REQ-005 SHALL have ports, in order:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  begin acquisition.
- clear  in  1  abort and zero counts.
- sample_limit  in  LIM_W  samples per run; 0 = unlimited.
- out  in  OUT_W  sampled state.
- update_cycle_done  in  1  out valid this cycle.
- tbl_we  in  1  tracked-state table write.
- tbl_addr  in  BIN_W=$clog2(NUM_BINS+1)  table index.
- tbl_data  in  OUT_W  table entry.
- rd_valid  out  1  readout word valid.
- rd_ready  in  1  readout accept.
- rd_bin  out  BIN_W  bin index of word.
- rd_count  out  CNT_W  bin count.
- rd_last  out  1  final word of readout.
- busy  out  1  ACQUIRE or DRAIN.
- done  out  1  readout complete (LED).

Function
REQ-006 FSM states IDLE, ACQUIRE, DRAIN, DONE; IDLE after reset.
REQ-007 start in IDLE/DONE: zero all bins and sample counter in the same edge; next state ACQUIRE.
REQ-008 start in ACQUIRE/DRAIN ignored; start and clear together: clear wins.
REQ-009 clear in any state: next state IDLE, all bins and sample counter zeroed, rd_valid low next cycle.
REQ-010 ACQUIRE: out/update_cycle_done registered one stage; bin updated on second rising edge after sample.
REQ-011 Match: lowest-index table entry equal to registered out increments; no match, no increment.
REQ-012 Bin counters saturate at 2^CNT_W-1.
REQ-013 Sample counter increments per accepted sample; when it reaches nonzero sample_limit, further samples ignored; DRAIN entered once the pipeline holds no pending update.
REQ-014 sample_limit sampled at start; changes during ACQUIRE have no effect.
REQ-015 DRAIN: emit bins 0..last ascending, one per rd_valid&&rd_ready; rd_valid asserted first cycle of DRAIN.
REQ-016 rd_bin/rd_count/rd_last stable while rd_valid && !rd_ready; rd_last high only with final word.
REQ-017 After final handshake: next state DONE, rd_valid low, done high; counts retained.
REQ-018 tbl_we honoured only in IDLE/DONE with tbl_addr < NUM_BINS; otherwise ignored.
REQ-019 busy high in ACQUIRE/DRAIN; done high only in DONE.

Reset
REQ-020 reset_n low: state IDLE, bins 0, sample counter 0, rd_valid/rd_last/busy/done 0, rd_bin/rd_count 0, table entry i = i.
REQ-021 Reset mid-ACQUIRE/DRAIN: pending pipeline sample discarded, no partial readout resumes.

Configuration
REQ-022 Macro HIST_OTHER_BIN_EN defined: extra bin index NUM_BINS counts unmatched samples (saturating); DRAIN emits NUM_BINS+1 words, rd_last on rd_bin==NUM_BINS.
REQ-023 Macro undefined: unmatched samples dropped; DRAIN emits NUM_BINS words, rd_last on rd_bin==NUM_BINS-1.

Structure
REQ-024 Package hist_pkg SHALL hold FSM state enum hist_state_e and default OUT_W/CNT_W/LIM_W constants.
REQ-025 Sub-module hist_match_encoder SHALL perform combinational priority match (table, value -> hit, bin index).

Verification
REQ-026 Reset, start, limit 4, out=3,3,7,200 (no macro) -> readout bin3=2, bin7=1, others 0, 90 words, rd_last on bin 89.
REQ-027 Same with HIST_OTHER_BIN_EN -> 91 words, bin 90 = 1.
REQ-028 CNT_W=4, 20 samples of out=5 -> bin5 reads 15.
REQ-029 rd_ready low 3 cycles per word -> rd_bin/rd_count held stable, no word lost or duplicated.
REQ-030 clear after 2 of 10 samples, then start -> fresh run, counts reflect only new run; start+clear same cycle -> IDLE.
REQ-031 tbl write entry 0 = 42 in IDLE, write during ACQUIRE ignored; out=42 -> bin0 increments.
